// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_pkg;

    // Sequencer states. FAULT is only left through reset.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FAULT = 2'd2
    } pcState_t;

    // Redirect priority codes; a larger code wins.
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_J    = 2'd1;
    localparam logic [1:0] PRI_JR   = 2'd2;
    localparam logic [1:0] PRI_BR   = 2'd3;

    // PC loaded on reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Pending redirect held across a stall.
    typedef struct packed {
        logic        valid;
        logic [1:0]  pri;
        logic [31:0] target;
    } pend_t;

    // Instruction addresses must be word aligned.
    function automatic logic isAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_redirect_select.sv
// Picks the winning redirect among the live requests and the pending entry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; requests are level-sampled and never stalled here.
module pc_redirect_select
    import pc_pkg::*;
(
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic        jumpReg,
    input  logic [31:0] jrTarget,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        pendValid,
    input  logic [1:0]  pendPri,
    input  logic [31:0] pendTarget,
    output logic        selValid,
    output logic [1:0]  selPri,
    output logic [31:0] selTarget
);

    logic        newValid;
    logic [1:0]  newPri;
    logic [31:0] newTarget;

    // Fixed-priority pick among this cycle's requests: branch > JR > jump.
    always_comb begin
        newValid  = 1'b0;
        newPri    = PRI_NONE;
        newTarget = 32'h0;
        if (branchTaken) begin
            newValid  = 1'b1;
            newPri    = PRI_BR;
            newTarget = branchTarget;
        end else if (jumpReg) begin
            newValid  = 1'b1;
            newPri    = PRI_JR;
            newTarget = jrTarget;
        end else if (jump) begin
            newValid  = 1'b1;
            newPri    = PRI_J;
            newTarget = jumpTarget;
        end
    end

    // A new request replaces the pending one on equal or higher priority,
    // so the most recent of two equal-priority redirects is the one kept.
    always_comb begin
        selValid  = 1'b0;
        selPri    = PRI_NONE;
        selTarget = 32'h0;
        if (newValid && (newPri >= pendPri)) begin
            selValid  = 1'b1;
            selPri    = newPri;
            selTarget = newTarget;
        end else if (pendValid) begin
            selValid  = 1'b1;
            selPri    = pendPri;
            selTarget = pendTarget;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the 5-stage pipeline with redirect buffering and alignment trap.
// Latency: redirects load PC at the next edge; PCAddResult is combinational.
// Backpressure: never back-pressures; redirects seen during a stall are buffered.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] JRTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PCResult,
    output logic [31:0] PCAddResult,
    output logic        IF_Flush,
    output logic        AddrFault
);

    pcState_t    state;
    pend_t       pend;
    logic        selValid;
    logic [1:0]  selPri;
    logic [31:0] selTarget;
    logic        selAligned;

    pc_redirect_select uSelect (
        .jump         (Jump),
        .jumpTarget   (JumpTarget),
        .jumpReg      (JumpReg),
        .jrTarget     (JRTarget),
        .branchTaken  (BranchTaken),
        .branchTarget (BranchTarget),
        .pendValid    (pend.valid),
        .pendPri      (pend.pri),
        .pendTarget   (pend.target),
        .selValid     (selValid),
        .selPri       (selPri),
        .selTarget    (selTarget)
    );

    assign selAligned = isAligned(selTarget[1:0]);

    // Sequential successor wraps naturally at 2^32.
    assign PCAddResult = PCResult + 32'd4;

    // Flush IF/ID whenever a redirect is applied this cycle; a trapped
    // sequencer keeps the front end flushed until reset.
    always_comb begin
        IF_Flush = 1'b0;
        case (state)
            RUN:     IF_Flush = PCWrite && selValid;
            PEND:    IF_Flush = PCWrite;
            FAULT:   IF_Flush = 1'b1;
            default: IF_Flush = 1'b0;
        endcase
    end

    // PC register, pending buffer and fault trap, advanced as one FSM.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= RUN;
            PCResult  <= RESET_PC;
            pend      <= '0;
            AddrFault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (PCWrite) begin
                        if (!selValid) begin
                            PCResult <= PCAddResult;
                        end else if (selAligned) begin
                            PCResult <= selTarget;
                        end else begin
                            state     <= FAULT;
                            AddrFault <= 1'b1;
                        end
                    end else if (selValid) begin
                        // Alignment is checked when the entry is applied, not here.
                        pend  <= '{valid: 1'b1, pri: selPri, target: selTarget};
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (PCWrite) begin
                        pend <= '0;
                        if (selAligned) begin
                            PCResult <= selTarget;
                            state    <= RUN;
                        end else begin
                            state     <= FAULT;
                            AddrFault <= 1'b1;
                        end
                    end else begin
                        // selValid is always set here; a weaker request yields the old entry.
                        pend <= '{valid: 1'b1, pri: selPri, target: selTarget};
                    end
                end
                FAULT: begin
                    AddrFault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    AddrFault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for the program-counter sequencer.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled before the next one.
// Backpressure: not applicable.
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        PCWrite;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] JRTarget;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        IF_Flush;
    logic        AddrFault;

    int checkCount = 0;
    int errorCount = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCWrite      (PCWrite),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .JumpReg      (JumpReg),
        .JRTarget     (JRTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .IF_Flush     (IF_Flush),
        .AddrFault    (AddrFault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point for every check in the bench.
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearReqs();
        Jump        = 1'b0;
        JumpReg     = 1'b0;
        BranchTaken = 1'b0;
        JumpTarget   = 32'h0;
        JRTarget     = 32'h0;
        BranchTarget = 32'h0;
    endtask

    initial begin
        Reset   = 1'b0;
        PCWrite = 1'b1;
        clearReqs();

        // Reset state
        #12;
        checkVal("rst_pc",    PCResult,    32'h0);
        checkVal("rst_pcadd", PCAddResult, 32'h4);
        checkVal("rst_flush", {31'h0, IF_Flush},  32'h0);
        checkVal("rst_fault", {31'h0, AddrFault}, 32'h0);
        Reset = 1'b1;
        #1;
        checkVal("rel_pc", PCResult, 32'h0);

        // Sequential fetch: 4, 8, C, 10
        for (int i = 1; i <= 4; i++) begin
            step();
            checkVal("seq_pc",    PCResult,    32'(4 * i));
            checkVal("seq_pcadd", PCAddResult, 32'(4 * i + 4));
            checkVal("seq_flush", {31'h0, IF_Flush}, 32'h0);
        end

        // Jump from 0x10
        Jump = 1'b1; JumpTarget = 32'h0040_0020;
        #1;
        checkVal("j_flush_now", {31'h0, IF_Flush}, 32'h1);
        step();
        clearReqs();
        #1;
        checkVal("j_pc",       PCResult,    32'h0040_0020);
        checkVal("j_pcadd",    PCAddResult, 32'h0040_0024);
        checkVal("j_flush_end", {31'h0, IF_Flush}, 32'h0);

        // Simultaneous redirects: branch wins
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        JumpReg     = 1'b1; JRTarget     = 32'h200;
        Jump        = 1'b1; JumpTarget   = 32'h300;
        step();
        clearReqs();
        #1;
        checkVal("pri_pc", PCResult, 32'h100);

        // Stall with J then BR buffered; BR applied on release
        PCWrite = 1'b0;
        Jump = 1'b1; JumpTarget = 32'h300;
        #1;
        checkVal("st1_flush", {31'h0, IF_Flush}, 32'h0);
        step();
        clearReqs();
        BranchTaken = 1'b1; BranchTarget = 32'h80;
        #1;
        checkVal("st2_pc",    PCResult, 32'h100);
        checkVal("st2_flush", {31'h0, IF_Flush}, 32'h0);
        step();
        clearReqs();
        #1;
        checkVal("st3_pc", PCResult, 32'h100);
        step();
        checkVal("st4_pc", PCResult, 32'h100);
        PCWrite = 1'b1;
        #1;
        checkVal("st_rel_flush", {31'h0, IF_Flush}, 32'h1);
        step();
        checkVal("st_rel_pc",    PCResult, 32'h80);
        checkVal("st_rel_flush_end", {31'h0, IF_Flush}, 32'h0);

        // Wraparound at top of address space
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        step();
        clearReqs();
        #1;
        checkVal("wrap_pc",    PCResult,    32'hFFFF_FFFC);
        checkVal("wrap_pcadd", PCAddResult, 32'h0);
        step();
        checkVal("wrap_next",  PCResult,    32'h0);

        // Lower-priority request during PEND is dropped
        PCWrite = 1'b0;
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        clearReqs();
        Jump = 1'b1; JumpTarget = 32'h300;
        step();
        clearReqs();
        #1;
        checkVal("pend_hold", PCResult, 32'h0);
        PCWrite = 1'b1;
        step();
        checkVal("pend_lowpri_pc", PCResult, 32'h40);

        // Reset mid-PEND discards the buffer
        PCWrite = 1'b0;
        Jump = 1'b1; JumpTarget = 32'h500;
        step();
        clearReqs();
        PCWrite = 1'b1;
        Reset = 1'b0;
        #1;
        checkVal("arst_pc",    PCResult, 32'h0);
        checkVal("arst_flush", {31'h0, IF_Flush}, 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        checkVal("arst_rel_flush", {31'h0, IF_Flush}, 32'h0);
        step();
        checkVal("arst_next_pc", PCResult, 32'h4);

        // Misaligned JR traps; later requests ignored until reset
        JumpReg = 1'b1; JRTarget = 32'h0000_0102;
        step();
        clearReqs();
        #1;
        checkVal("flt_pc",    PCResult, 32'h4);
        checkVal("flt_fault", {31'h0, AddrFault}, 32'h1);
        checkVal("flt_flush", {31'h0, IF_Flush},  32'h1);
        Jump = 1'b1; JumpTarget = 32'h600;
        step();
        clearReqs();
        step();
        checkVal("flt_hold_pc",    PCResult, 32'h4);
        checkVal("flt_hold_fault", {31'h0, AddrFault}, 32'h1);
        Reset = 1'b0;
        #1;
        checkVal("flt_rst_fault", {31'h0, AddrFault}, 32'h0);
        checkVal("flt_rst_pc",    PCResult, 32'h0);
        Reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter for the 5-stage MIPS datapath.
- Produces PCResult for instruction fetch and PCAddResult (PC+4), which the jump-target concatenation stage consumes.
- Accepts three redirects: the J/JAL target from ID, the JR target from ID, and the taken-branch target from EX.
- Handles stalls by buffering any redirect that arrives while the PC is frozen, drives the IF/ID flush, and traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- PCWrite  in  1  1 = PC may advance; 0 = hazard stall, PC holds
- Jump  in  1  ID-stage J/JAL decoded
- JumpTarget  in  32  concatenated jump target
- JumpReg  in  1  ID-stage JR decoded
- JRTarget  in  32  forwarded rs value
- BranchTaken  in  1  EX-stage branch resolved taken
- BranchTarget  in  32  EX-stage PC+4+(imm<<2)
- PCResult  out  32  current PC
- PCAddResult  out  32  PCResult+4
- IF_Flush  out  1  clear IF/ID at the next edge
- AddrFault  out  1  sticky misaligned-target trap

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - PCResult=RESET_PC
  - state=RUN
  - pending buffer empty (PendValid=0, PendTarget=0, PendPri=0)
  - AddrFault=0
  - IF_Flush therefore reads 0
- PCAddResult = PCResult + 32'd4, mod 2^32, so 32'hFFFF_FFFC wraps to 0. It is combinational, with zero latency.
- Redirect priority: BranchTaken (pri 3) > JumpReg (pri 2) > Jump (pri 1). Only the highest active request is considered.
- "Candidate" = the new request when its pri >= PendPri; otherwise the pending entry.
- States:
  - RUN, PCWrite=1:
    - With a request: PC <= target; IF_Flush=1 in that cycle.
    - With no request: PC <= PC+4; IF_Flush=0.
  - RUN, PCWrite=0:
    - With a request: capture target/pri into the pending buffer, go to PEND, PC holds, IF_Flush=0.
    - With no request: hold.
  - PEND, PCWrite=0:
    - A new request with pri >= PendPri overwrites the buffer; otherwise it is ignored.
    - PC holds.
  - PEND, PCWrite=1:
    - PC <= candidate target; IF_Flush=1; buffer cleared; go to RUN.
  - FAULT:
    - PC frozen, AddrFault=1, IF_Flush=1 continuously, all requests ignored.
    - Exit only via reset.
- Alignment: if the target about to be loaded into PC (direct request or pending) has bits[1:0] != 0, the PC is not updated. The block enters FAULT at that edge; AddrFault rises the same edge.
- Misaligned targets captured into the buffer are checked only on application, not on capture.
- Requests are level-sampled each cycle. The producer holds them only for one cycle; the block never back-pressures.
- An asynchronous reset mid-stall discards the pending buffer.

Decomposition:
- Shared package pc_pkg holds:
  - state encodings RUN=2'd0, PEND=2'd1, FAULT=2'd2
  - priority codes PRI_NONE=0, PRI_J=1, PRI_JR=2, PRI_BR=3
  - default RESET_PC
- One combinational sub-module, pc_redirect_select: takes the request/target inputs and the pending entry, and returns the winning target, its pri, and a valid flag.
- The FSM, the PC register and the buffer remain in pc_sequencer.

Test Plan:
- Reset release with no requests, PCWrite=1 for 4 cycles -> PCResult 0,4,8,C,10; PCAddResult always +4; IF_Flush=0.
- At PC=0x10, pulse Jump with JumpTarget=0x0040_0020 -> next PC=0x0040_0020; IF_Flush=1 exactly one cycle.
- Same cycle: BranchTaken (0x100), JumpReg (0x200) and Jump (0x300) -> PC=0x100.
- PCWrite=0 for 3 cycles while Jump(0x300) pulses in cycle 1 and BranchTaken(0x80) in cycle 2; then PCWrite=1 -> PC holds throughout the stall, then loads 0x80 with IF_Flush=1; the Jump target is discarded.
- JumpReg with JRTarget=0x0000_0102 -> PC holds, AddrFault=1 next edge and stays 1; later valid requests are ignored until Reset=0.
- PC forced to 0xFFFF_FFFC (via branch) -> PCAddResult=0 and next sequential PC=0. Asserting Reset mid-PEND -> PC=RESET_PC immediately and no flush after release.
